// File: rtl/atm_pkg.sv
// Shared definitions for the ATM transaction sequencer: operation codes,
// status codes and the sequencer state encoding.
package atm_pkg;

    // Operation requested by the front end
    typedef enum logic [1:0] {
        OP_QUERY = 2'b00,
        OP_DEP   = 2'b01,
        OP_WDR   = 2'b10,
        OP_ILL   = 2'b11
    } op_e;

    // Completion status reported alongside done
    typedef enum logic [1:0] {
        ERR_OK  = 2'b00,
        ERR_NSF = 2'b01,
        ERR_OVF = 2'b10,
        ERR_ILL = 2'b11
    } err_e;

    // Sequencer states, one transaction walks IDLE -> READ -> CHECK -> (WRITE) -> DONE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/atm_txn_alu.sv
// Combinational balance arithmetic for one transaction. Given the current
// balance, operand and operation it produces the new balance, a status code
// and whether the result should be committed to the register file.
// Optional build macro: WDRAW_LIMIT_EN adds a per-transaction withdraw cap.
module atm_txn_alu
    import atm_pkg::*;
#(
    parameter int DATA_W = 32
`ifdef WDRAW_LIMIT_EN
    , parameter logic [DATA_W-1:0] MAX_WDRAW = 32'd500
`endif
)(
    input  logic [DATA_W-1:0] i_bal,
    input  logic [DATA_W-1:0] i_amount,
    input  op_e               i_op,
    output logic [DATA_W-1:0] o_result,
    output err_e              o_err,
    output logic              o_write
);

    logic [DATA_W:0] w_sum;
    logic            w_overLimit;

    assign w_sum = {1'b0, i_bal} + {1'b0, i_amount};

`ifdef WDRAW_LIMIT_EN
    assign w_overLimit = (i_amount > MAX_WDRAW);
`else
    assign w_overLimit = 1'b0;
`endif

    // Evaluate the operation; errors leave the balance untouched and suppress the write
    always_comb begin
        o_result = i_bal;
        o_err    = ERR_OK;
        o_write  = 1'b0;
        case (i_op)
            OP_QUERY: begin
                o_err = ERR_OK;
            end
            OP_DEP: begin
                if (w_sum[DATA_W]) begin
                    o_err = ERR_OVF;
                end else begin
                    o_result = w_sum[DATA_W-1:0];
                    o_write  = 1'b1;
                end
            end
            OP_WDR: begin
                if (w_overLimit) begin
                    o_err = ERR_ILL;
                end else if (i_amount > i_bal) begin
                    o_err = ERR_NSF;
                end else begin
                    o_result = i_bal - i_amount;
                    o_write  = 1'b1;
                end
            end
            default: begin
                o_err = ERR_ILL;
            end
        endcase
    end

endmodule

// File: rtl/atm_txn_sequencer.sv
// Runs one account transaction at a time against the balance register file
// with a req/done handshake: latch request, read balance, check, optionally
// write back with a single-cycle write enable, then report status.
// Optional build macro: WDRAW_LIMIT_EN enables the MAX_WDRAW withdraw cap.
module atm_txn_sequencer
    import atm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_ACCT = 16
`ifdef WDRAW_LIMIT_EN
    , parameter logic [DATA_W-1:0] MAX_WDRAW = 32'd500
`endif
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic [1:0]                op,
    input  logic [$clog2(N_ACCT)-1:0] acct,
    input  logic [DATA_W-1:0]         amount,
    output logic [$clog2(N_ACCT)-1:0] rf_sel,
    output logic                      rf_we,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [DATA_W-1:0]         rf_rdata,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                err,
    output logic [DATA_W-1:0]         balance
);

    localparam int SEL_W = $clog2(N_ACCT);

    state_e              r_state;
    state_e              w_nextState;
    op_e                 r_op;
    logic [SEL_W-1:0]    r_sel;
    logic [DATA_W-1:0]   r_amount;
    logic [DATA_W-1:0]   r_bal;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_balance;
    err_e                r_err;

    logic [DATA_W-1:0]   w_aluResult;
    err_e                w_aluErr;
    logic                w_aluWrite;

    atm_txn_alu #(
        .DATA_W    (DATA_W)
`ifdef WDRAW_LIMIT_EN
        , .MAX_WDRAW (MAX_WDRAW)
`endif
    ) u_alu (
        .i_bal    (r_bal),
        .i_amount (r_amount),
        .i_op     (r_op),
        .o_result (w_aluResult),
        .o_err    (w_aluErr),
        .o_write  (w_aluWrite)
    );

    // State register; reset aborts any transaction, including a write in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and state-decoded handshake/write strobes
    always_comb begin
        w_nextState = r_state;
        rf_we       = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    w_nextState = ST_READ;
                end
            end
            ST_READ: begin
                w_nextState = ST_CHECK;
            end
            ST_CHECK: begin
                w_nextState = w_aluWrite ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: begin
                rf_we       = 1'b1;
                w_nextState = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Operand latching, balance capture and result registers advanced by state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= OP_QUERY;
            r_sel     <= '0;
            r_amount  <= '0;
            r_bal     <= '0;
            r_wdata   <= '0;
            r_balance <= '0;
            r_err     <= ERR_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_op     <= op_e'(op);
                        r_sel    <= acct;
                        r_amount <= amount;
                    end
                end
                ST_READ: begin
                    r_bal <= rf_rdata;
                end
                ST_CHECK: begin
                    if (w_aluWrite) begin
                        r_wdata <= w_aluResult;
                    end else begin
                        r_balance <= r_bal;
                        r_err     <= w_aluErr;
                    end
                end
                ST_WRITE: begin
                    r_balance <= r_wdata;
                    r_err     <= ERR_OK;
                end
                default: begin
                end
            endcase
        end
    end

    assign rf_sel   = r_sel;
    assign rf_wdata = r_wdata;
    assign err      = r_err;
    assign balance  = r_balance;

endmodule

// File: tb/tb_atm_txn_sequencer.sv
// Directed testbench for atm_txn_sequencer with a behavioural 16-entry
// balance register file. Expected values are hand-computed constants.
module tb_atm_txn_sequencer;

    logic        clk;
    logic        rst;
    logic        req;
    logic [1:0]  op;
    logic [3:0]  acct;
    logic [31:0] amount;
    logic [3:0]  rf_sel;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [31:0] balance;

    logic [31:0] rfMem [16];
    logic        loadMem;

    int checks;
    int errors;

    int          weCount;
    int          weCycle;
    logic [3:0]  weSel;
    logic [31:0] weData;
    int          doneCycle;
    logic        gotDone;
    logic        busyFirst;
    logic        busyAfter;
    logic [1:0]  doneErr;
    logic [31:0] doneBal;
    int          extraDone;
    logic        weSeen;

    atm_txn_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op       (op),
        .acct     (acct),
        .amount   (amount),
        .rf_sel   (rf_sel),
        .rf_we    (rf_we),
        .rf_wdata (rf_wdata),
        .rf_rdata (rf_rdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .balance  (balance)
    );

    // Free-running clock, active edge is posedge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: combinational read, write on rf_we
    assign rf_rdata = rfMem[rf_sel];
    always @(posedge clk) begin
        if (loadMem) begin
            for (int i = 0; i < 16; i++) rfMem[i] <= 32'd0;
            rfMem[5] <= 32'hFFFF_FFFE;
            rfMem[7] <= 32'd42;
            rfMem[9] <= 32'd1000;
        end else if (rf_we) begin
            rfMem[rf_sel] <= rf_wdata;
        end
    end

    // Run-away guard
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issue one request and trace the transaction until done (bounded)
    task automatic applyStimulus(input logic [1:0] o, input logic [3:0] a, input logic [31:0] amt, input bit hold);
        @(negedge clk);
        req    = 1'b1;
        op     = o;
        acct   = a;
        amount = amt;
        weCount = 0; weCycle = 0; weSel = '0; weData = '0;
        doneCycle = 0; gotDone = 1'b0; busyFirst = 1'b0; busyAfter = 1'b1;
        doneErr = '0; doneBal = '0;
        @(posedge clk);
        #1;
        if (!hold) begin
            req    = 1'b0;
            op     = 2'b11;
            acct   = 4'hF;
            amount = 32'hDEAD_BEEF;
        end
        for (int c = 1; c <= 12 && !gotDone; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c == 1) busyFirst = busy;
            if (rf_we) begin
                weCount++;
                weCycle = c;
                weSel   = rf_sel;
                weData  = rf_wdata;
            end
            if (done) begin
                gotDone   = 1'b1;
                doneCycle = c;
                doneErr   = err;
                doneBal   = balance;
                req       = 1'b0;
            end
        end
        checkOutput("doneSeen", {31'd0, gotDone}, 32'd1);
        @(posedge clk);
        #1;
        busyAfter = busy;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        loadMem = 1'b1;
        req     = 1'b0;
        op      = 2'b00;
        acct    = 4'd0;
        amount  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);
        checkOutput("rstWe", {31'd0, rf_we}, 32'd0);
        checkOutput("rstSel", {28'd0, rf_sel}, 32'd0);
        checkOutput("rstWdata", rf_wdata, 32'd0);
        checkOutput("rstErr", {30'd0, err}, 32'd0);
        checkOutput("rstBal", balance, 32'd0);
        @(negedge clk);
        loadMem = 1'b0;
        rst     = 1'b0;

        $display("[TB] deposit 250 to acct 3");
        applyStimulus(2'b01, 4'd3, 32'd250, 1'b0);
        checkOutput("dep1BusyFirst", {31'd0, busyFirst}, 32'd1);
        checkOutput("dep1WeCount", weCount, 32'd1);
        checkOutput("dep1WeCycle", weCycle, 32'd3);
        checkOutput("dep1WeSel", {28'd0, weSel}, 32'd3);
        checkOutput("dep1WeData", weData, 32'd250);
        checkOutput("dep1DoneCycle", doneCycle, 32'd4);
        checkOutput("dep1Err", {30'd0, doneErr}, 32'd0);
        checkOutput("dep1Bal", doneBal, 32'd250);
        checkOutput("dep1BusyAfter", {31'd0, busyAfter}, 32'd0);

        $display("[TB] withdraw 100 from acct 3");
        applyStimulus(2'b10, 4'd3, 32'd100, 1'b0);
        checkOutput("wdr1WeData", weData, 32'd150);
        checkOutput("wdr1Err", {30'd0, doneErr}, 32'd0);
        checkOutput("wdr1Bal", doneBal, 32'd150);

        $display("[TB] withdraw 151 from acct 3 (insufficient)");
        applyStimulus(2'b10, 4'd3, 32'd151, 1'b0);
        checkOutput("nsfWeCount", weCount, 32'd0);
        checkOutput("nsfErr", {30'd0, doneErr}, 32'd1);
        checkOutput("nsfBal", doneBal, 32'd150);
        checkOutput("nsfDoneCycle", doneCycle, 32'd3);

        $display("[TB] deposit 5 onto FFFFFFFE (overflow)");
        applyStimulus(2'b01, 4'd5, 32'd5, 1'b0);
        checkOutput("ovfWeCount", weCount, 32'd0);
        checkOutput("ovfErr", {30'd0, doneErr}, 32'd2);
        checkOutput("ovfBal", doneBal, 32'hFFFF_FFFE);

        $display("[TB] deposit 1 onto FFFFFFFE (exact max)");
        applyStimulus(2'b01, 4'd5, 32'd1, 1'b0);
        checkOutput("maxWeData", weData, 32'hFFFF_FFFF);
        checkOutput("maxErr", {30'd0, doneErr}, 32'd0);

        $display("[TB] withdraw 150 from 150 (to zero)");
        applyStimulus(2'b10, 4'd3, 32'd150, 1'b0);
        checkOutput("zeroWeCount", weCount, 32'd1);
        checkOutput("zeroWeData", weData, 32'd0);
        checkOutput("zeroErr", {30'd0, doneErr}, 32'd0);

        $display("[TB] illegal op on acct 7");
        applyStimulus(2'b11, 4'd7, 32'd10, 1'b0);
        checkOutput("illWeCount", weCount, 32'd0);
        checkOutput("illErr", {30'd0, doneErr}, 32'd3);
        checkOutput("illBal", doneBal, 32'd42);

        $display("[TB] query acct 7");
        applyStimulus(2'b00, 4'd7, 32'd0, 1'b0);
        checkOutput("qryWeCount", weCount, 32'd0);
        checkOutput("qryErr", {30'd0, doneErr}, 32'd0);
        checkOutput("qryBal", doneBal, 32'd42);
        checkOutput("qryDoneCycle", doneCycle, 32'd3);

        $display("[TB] deposit 0 to acct 7 with req held through busy");
        applyStimulus(2'b01, 4'd7, 32'd0, 1'b1);
        checkOutput("holdWeCount", weCount, 32'd1);
        checkOutput("holdWeData", weData, 32'd42);
        checkOutput("holdWeSel", {28'd0, weSel}, 32'd7);
        extraDone = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (done) extraDone++;
        end
        checkOutput("holdExtraDone", extraDone, 32'd0);

        $display("[TB] reset during write");
        @(negedge clk);
        req = 1'b1; op = 2'b01; acct = 4'd6; amount = 32'd77;
        @(posedge clk);
        #1;
        req = 1'b0;
        weSeen = 1'b0;
        for (int c = 1; c <= 10 && !weSeen; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (rf_we) weSeen = 1'b1;
        end
        checkOutput("abortWeSeen", {31'd0, weSeen}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abortWe", {31'd0, rf_we}, 32'd0);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortSel", {28'd0, rf_sel}, 32'd0);
        checkOutput("abortWdata", rf_wdata, 32'd0);
        checkOutput("abortBal", balance, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortMem", rfMem[6], 32'd0);
        applyStimulus(2'b01, 4'd6, 32'd10, 1'b0);
        checkOutput("postRstWeData", weData, 32'd10);
        checkOutput("postRstBal", doneBal, 32'd10);
        checkOutput("postRstDoneCycle", doneCycle, 32'd4);

`ifdef WDRAW_LIMIT_EN
        $display("[TB] withdraw cap enabled");
        applyStimulus(2'b10, 4'd9, 32'd600, 1'b0);
        checkOutput("capWeCount", weCount, 32'd0);
        checkOutput("capErr", {30'd0, doneErr}, 32'd3);
        checkOutput("capBal", doneBal, 32'd1000);
        applyStimulus(2'b10, 4'd9, 32'd500, 1'b0);
        checkOutput("capEdgeWeData", weData, 32'd500);
        checkOutput("capEdgeErr", {30'd0, doneErr}, 32'd0);
`else
        $display("[TB] withdraw cap disabled");
        applyStimulus(2'b10, 4'd9, 32'd600, 1'b0);
        checkOutput("noCapWeData", weData, 32'd400);
        checkOutput("noCapErr", {30'd0, doneErr}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
